// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Two requesters share one external 4096x32 byte-masked SRAM (one write
// port, one read port). Grants are round-robin with at most one grant per
// cycle. A read response is held in the RESP state until the owning
// requester accepts it. Accepting a response and taking a new read grant in
// the same cycle keeps one read per cycle flowing.
// Optional feature: define SRAM_ARB_PERF_EN to add 32-bit grant and stall
// counters (io_perf_grant_0, io_perf_grant_1, io_perf_stall).

module sram_port_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic        io_req_0_valid,
    output logic        io_req_0_ready,
    input  logic        io_req_0_bits_write,
    input  logic [11:0] io_req_0_bits_addr,
    input  logic [31:0] io_req_0_bits_wdata,
    input  logic [3:0]  io_req_0_bits_mask,

    input  logic        io_req_1_valid,
    output logic        io_req_1_ready,
    input  logic        io_req_1_bits_write,
    input  logic [11:0] io_req_1_bits_addr,
    input  logic [31:0] io_req_1_bits_wdata,
    input  logic [3:0]  io_req_1_bits_mask,

    output logic        io_resp_0_valid,
    input  logic        io_resp_0_ready,
    output logic [31:0] io_resp_0_bits_rdata,

    output logic        io_resp_1_valid,
    input  logic        io_resp_1_ready,
    output logic [31:0] io_resp_1_bits_rdata,

    output logic        mem_W0_en,
    output logic [11:0] mem_W0_addr,
    output logic [31:0] mem_W0_data,
    output logic [3:0]  mem_W0_mask,

    output logic        mem_R0_en,
    output logic [11:0] mem_R0_addr,
    input  logic [31:0] mem_R0_data
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0] io_perf_grant_0,
    output logic [31:0] io_perf_grant_1,
    output logic [31:0] io_perf_stall
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state;
    logic        prio;
    logic        owner;

    logic        resp_pending;
    logic        owner_ready;
    logic        resp_fire;
    logic        arb_active;
    logic        grant_0;
    logic        grant_1;
    logic        any_grant;

    logic        sel_write;
    logic [11:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_mask;

    // Decide whether a response is being accepted and whether a grant may happen
    always_comb begin
        resp_pending = (state == RESP) && !reset;
        owner_ready  = owner ? io_resp_1_ready : io_resp_0_ready;
        resp_fire    = resp_pending && owner_ready;
        arb_active   = !reset && ((state == IDLE) || resp_fire);
        grant_0      = arb_active && io_req_0_valid && (!prio || !io_req_1_valid);
        grant_1      = arb_active && io_req_1_valid && ( prio || !io_req_0_valid);
        any_grant    = grant_0 || grant_1;
    end

    // Route the granted requester's command toward the SRAM ports
    always_comb begin
        sel_write = grant_1 ? io_req_1_bits_write : io_req_0_bits_write;
        sel_addr  = grant_1 ? io_req_1_bits_addr  : io_req_0_bits_addr;
        sel_wdata = grant_1 ? io_req_1_bits_wdata : io_req_0_bits_wdata;
        sel_mask  = grant_1 ? io_req_1_bits_mask  : io_req_0_bits_mask;
    end

    assign io_req_0_ready       = grant_0;
    assign io_req_1_ready       = grant_1;

    assign io_resp_0_valid      = resp_pending && !owner;
    assign io_resp_1_valid      = resp_pending &&  owner;
    assign io_resp_0_bits_rdata = io_resp_0_valid ? mem_R0_data : 32'h0;
    assign io_resp_1_bits_rdata = io_resp_1_valid ? mem_R0_data : 32'h0;

    assign mem_W0_en            = any_grant && sel_write;
    assign mem_W0_addr          = mem_W0_en ? sel_addr  : 12'h0;
    assign mem_W0_data          = mem_W0_en ? sel_wdata : 32'h0;
    assign mem_W0_mask          = mem_W0_en ? sel_mask  : 4'h0;

    assign mem_R0_en            = any_grant && !sel_write;
    assign mem_R0_addr          = mem_R0_en ? sel_addr : 12'h0;

    // State, round-robin pointer and response owner
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
        end else begin
            if (any_grant) begin
                prio <= ~grant_1;
            end
            if (any_grant && !sel_write) begin
                state <= RESP;
                owner <= grant_1;
            end else if (resp_fire) begin
                state <= IDLE;
            end
        end
    end

`ifdef SRAM_ARB_PERF_EN
    // Count grants per requester and cycles where requests waited without a grant
    always_ff @(posedge clock) begin
        if (reset) begin
            io_perf_grant_0 <= 32'h0;
            io_perf_grant_1 <= 32'h0;
            io_perf_stall   <= 32'h0;
        end else begin
            if (grant_0) begin
                io_perf_grant_0 <= io_perf_grant_0 + 32'h1;
            end
            if (grant_1) begin
                io_perf_grant_1 <= io_perf_grant_1 + 32'h1;
            end
            if ((io_req_0_valid || io_req_1_valid) && !any_grant) begin
                io_perf_stall <= io_perf_stall + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Drives sram_port_arbiter against a behavioural SRAM and a transaction-level
// reference model: round-robin favoured requester, one outstanding response
// and a shadow copy of memory contents. Build with +define+SRAM_ARB_PERF_EN
// to also exercise the performance counters.

module tb_sram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [11:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_mask  [2];
    logic [1:0]  resp_ready;

    logic        ready0, ready1, rv0, rv1;
    logic [31:0] rdata0, rdata1;
    logic        w_en, r_en;
    logic [11:0] w_addr, r_addr;
    logic [31:0] w_data;
    logic [3:0]  w_mask;
    logic [31:0] sram_q;
    logic [1:0]  act_ready;
    logic [1:0]  act_rv;
`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_g0, perf_g1, perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] shadow [4096];
    bit          m_fav;
    bit          m_pend;
    bit          m_owner;
    logic [31:0] m_pdata;
    bit          g_any;
    bit          g_sel;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rv;
    logic        exp_w_en;
    logic        exp_r_en;

    // Behavioural SRAM environment
    logic [31:0] sram [4096];
    logic        preload;

    assign act_ready = {ready1, ready0};
    assign act_rv    = {rv1, rv0};

    always #5 clock = ~clock;

    sram_port_arbiter dut (
        .clock                (clock),
        .reset                (reset),
        .io_req_0_valid       (req_valid[0]),
        .io_req_0_ready       (ready0),
        .io_req_0_bits_write  (req_write[0]),
        .io_req_0_bits_addr   (req_addr[0]),
        .io_req_0_bits_wdata  (req_wdata[0]),
        .io_req_0_bits_mask   (req_mask[0]),
        .io_req_1_valid       (req_valid[1]),
        .io_req_1_ready       (ready1),
        .io_req_1_bits_write  (req_write[1]),
        .io_req_1_bits_addr   (req_addr[1]),
        .io_req_1_bits_wdata  (req_wdata[1]),
        .io_req_1_bits_mask   (req_mask[1]),
        .io_resp_0_valid      (rv0),
        .io_resp_0_ready      (resp_ready[0]),
        .io_resp_0_bits_rdata (rdata0),
        .io_resp_1_valid      (rv1),
        .io_resp_1_ready      (resp_ready[1]),
        .io_resp_1_bits_rdata (rdata1),
        .mem_W0_en            (w_en),
        .mem_W0_addr          (w_addr),
        .mem_W0_data          (w_data),
        .mem_W0_mask          (w_mask),
        .mem_R0_en            (r_en),
        .mem_R0_addr          (r_addr),
        .mem_R0_data          (sram_q)
`ifdef SRAM_ARB_PERF_EN
        ,
        .io_perf_grant_0      (perf_g0),
        .io_perf_grant_1      (perf_g1),
        .io_perf_stall        (perf_stall)
`endif
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h0F0F1234;
    endfunction

    // Byte-masked write port and registered read port of the external SRAM
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_word(i);
        end else begin
            if (w_en) begin
                for (int b = 0; b < 4; b++)
                    if (w_mask[b]) sram[w_addr][8*b +: 8] <= w_data[8*b +: 8];
            end
            if (r_en) sram_q <= sram[r_addr];
        end
    end

    // Predict this cycle's grant and visible response from the current inputs
    task automatic model_eval();
        bit act;
        act   = !reset && (!m_pend || resp_ready[m_owner]);
        g_any = 1'b0;
        g_sel = 1'b0;
        if (act) begin
            if (req_valid[m_fav]) begin
                g_any = 1'b1;
                g_sel = m_fav;
            end else if (req_valid[!m_fav]) begin
                g_any = 1'b1;
                g_sel = !m_fav;
            end
        end
        exp_ready = 2'b00;
        exp_rv    = 2'b00;
        exp_w_en  = 1'b0;
        exp_r_en  = 1'b0;
        if (g_any) begin
            exp_ready[g_sel] = 1'b1;
            if (req_write[g_sel]) exp_w_en = 1'b1;
            else                  exp_r_en = 1'b1;
        end
        if (m_pend && !reset) exp_rv[m_owner] = 1'b1;
    endtask

    // Apply the effect of this cycle's transactions to the model
    task automatic model_commit();
        if (reset) begin
            m_pend  = 1'b0;
            m_fav   = 1'b0;
            m_owner = 1'b0;
        end else begin
            if (m_pend && resp_ready[m_owner]) m_pend = 1'b0;
            if (g_any) begin
                m_fav = !g_sel;
                if (req_write[g_sel]) begin
                    for (int b = 0; b < 4; b++)
                        if (req_mask[g_sel][b])
                            shadow[req_addr[g_sel]][8*b +: 8] = req_wdata[g_sel][8*b +: 8];
                end else begin
                    m_pend  = 1'b1;
                    m_owner = g_sel;
                    m_pdata = shadow[req_addr[g_sel]];
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clock);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int n, input logic wr, input logic [11:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        req_write[n] = wr;
        req_addr[n]  = a;
        req_wdata[n] = d;
        req_mask[n]  = m;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        set_req(0, 1'b0, 12'h001, 32'h1, 4'hF);
        set_req(1, 1'b1, 12'h002, 32'h2, 4'hF);
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (act_ready !== 2'b00) begin
                failures++;
                $display("[TB] FAIL reset_ready got=%b want=00", act_ready);
            end
            checks++;
            if (act_rv !== 2'b00) begin
                failures++;
                $display("[TB] FAIL reset_resp_valid got=%b want=00", act_rv);
            end
            checks++;
            if ({w_en, r_en} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL reset_mem_en got=%b want=00", {w_en, r_en});
            end
            checks++;
            if ({w_addr, w_data, w_mask, r_addr} !== 60'h0) begin
                failures++;
                $display("[TB] FAIL reset_mem_bus got=%h want=0", {w_addr, w_data, w_mask, r_addr});
            end
            advance();
        end
        reset     = 1'b0;
        req_valid = 2'b00;
    endtask

    task automatic test_alternating_writes();
        logic [1:0]  want;
        logic [11:0] want_addr;
        logic [31:0] want_data;
        req_valid = 2'b11;
        set_req(0, 1'b1, 12'h010, 32'h11111111, 4'hF);
        set_req(1, 1'b1, 12'h020, 32'h22222222, 4'hF);
        for (int i = 0; i < 4; i++) begin
            settle();
            want      = (i % 2 == 0) ? 2'b01 : 2'b10;
            want_addr = (i % 2 == 0) ? 12'h010 : 12'h020;
            want_data = (i % 2 == 0) ? 32'h11111111 : 32'h22222222;
            checks++;
            if (act_ready !== want || act_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL alt_grant[%0d] got=%b want=%b", i, act_ready, want);
            end
            checks++;
            if (w_en !== 1'b1 || r_en !== 1'b0 || w_addr !== want_addr || w_data !== want_data) begin
                failures++;
                $display("[TB] FAIL alt_write[%0d] got en=%b addr=%h data=%h want addr=%h data=%h",
                         i, w_en, w_addr, w_data, want_addr, want_data);
            end
            advance();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_masked_write_read();
        resp_ready = 2'b11;
        req_valid  = 2'b01;
        set_req(0, 1'b1, 12'h3FF, 32'hAABBCCDD, 4'b0101);
        settle();
        checks++;
        if (act_ready !== 2'b01 || w_en !== 1'b1 || w_mask !== 4'b0101 ||
            w_data !== 32'hAABBCCDD || w_addr !== 12'h3FF) begin
            failures++;
            $display("[TB] FAIL mask_write got ready=%b en=%b mask=%b data=%h addr=%h want 01/1/0101/aabbccdd/3ff",
                     act_ready, w_en, w_mask, w_data, w_addr);
        end
        advance();
        req_valid = 2'b10;
        set_req(1, 1'b0, 12'h3FF, 32'h0, 4'h0);
        settle();
        checks++;
        if (act_ready !== 2'b10 || r_en !== 1'b1 || r_addr !== 12'h3FF) begin
            failures++;
            $display("[TB] FAIL mask_read_grant got ready=%b ren=%b raddr=%h want 10/1/3ff", act_ready, r_en, r_addr);
        end
        advance();
        req_valid = 2'b00;
        settle();
        checks++;
        if (act_rv !== 2'b10) begin
            failures++;
            $display("[TB] FAIL mask_resp_valid got=%b want=10", act_rv);
        end
        checks++;
        if (rdata1[23:16] !== 8'hBB || rdata1[7:0] !== 8'hDD) begin
            failures++;
            $display("[TB] FAIL mask_bytes got=%h want bytes2/0=bb/dd", rdata1);
        end
        checks++;
        if (rdata1 !== m_pdata) begin
            failures++;
            $display("[TB] FAIL mask_rdata got=%h want=%h", rdata1, m_pdata);
        end
        advance();
        settle();
        checks++;
        if (act_rv !== 2'b00) begin
            failures++;
            $display("[TB] FAIL mask_resp_done got=%b want=00", act_rv);
        end
        advance();
    endtask

    task automatic test_zero_mask();
        logic [31:0] saved;
        saved      = shadow[12'h123];
        resp_ready = 2'b11;
        req_valid  = 2'b01;
        set_req(0, 1'b1, 12'h123, ~saved, 4'b0000);
        settle();
        checks++;
        if (act_ready !== 2'b01 || w_en !== 1'b1 || w_mask !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL zero_mask_write got ready=%b en=%b mask=%b want 01/1/0000", act_ready, w_en, w_mask);
        end
        advance();
        set_req(0, 1'b0, 12'h123, 32'h0, 4'h0);
        settle();
        advance();
        req_valid = 2'b00;
        settle();
        checks++;
        if (rv0 !== 1'b1 || rdata0 !== saved) begin
            failures++;
            $display("[TB] FAIL zero_mask_read got valid=%b data=%h want 1/%h", rv0, rdata0, saved);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        resp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 4) ? 2'b01 : 2'b00;
            set_req(0, 1'b0, 12'(i), 32'h0, 4'h0);
            settle();
            if (i < 4) begin
                checks++;
                if (act_ready !== 2'b01 || r_en !== 1'b1 || r_addr !== 12'(i)) begin
                    failures++;
                    $display("[TB] FAIL b2b_grant[%0d] got ready=%b ren=%b addr=%h want 01/1/%h",
                             i, act_ready, r_en, r_addr, 12'(i));
                end
            end
            if (i > 0) begin
                checks++;
                if (act_rv !== 2'b01 || rdata0 !== init_word(i - 1) || rdata0 !== m_pdata) begin
                    failures++;
                    $display("[TB] FAIL b2b_resp[%0d] got valid=%b data=%h want 01/%h",
                             i, act_rv, rdata0, init_word(i - 1));
                end
            end
            advance();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_stall();
        resp_ready = 2'b00;
        req_valid  = 2'b01;
        set_req(0, 1'b0, 12'h3FF, 32'h0, 4'h0);
        settle();
        checks++;
        if (act_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL stall_read_grant got=%b want=01", act_ready);
        end
        advance();
        req_valid = 2'b10;
        set_req(1, 1'b1, 12'h055, 32'h0550CAFE, 4'hF);
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if (act_ready !== 2'b00 || w_en !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_block[%0d] got ready=%b wen=%b want 00/0", i, act_ready, w_en);
            end
            checks++;
            if (act_rv !== 2'b01 || rdata0 !== m_pdata) begin
                failures++;
                $display("[TB] FAIL stall_hold[%0d] got valid=%b data=%h want 01/%h", i, act_rv, rdata0, m_pdata);
            end
            advance();
        end
        resp_ready = 2'b01;
        settle();
        checks++;
        if (act_ready !== 2'b10 || w_en !== 1'b1 || w_addr !== 12'h055 || act_rv !== 2'b01) begin
            failures++;
            $display("[TB] FAIL stall_release got ready=%b wen=%b addr=%h valid=%b want 10/1/055/01",
                     act_ready, w_en, w_addr, act_rv);
        end
        advance();
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        settle();
        checks++;
        if (act_rv !== 2'b00) begin
            failures++;
            $display("[TB] FAIL stall_done got=%b want=00", act_rv);
        end
        advance();
    endtask

    task automatic test_reset_in_resp();
        resp_ready = 2'b00;
        req_valid  = 2'b01;
        set_req(0, 1'b0, 12'h055, 32'h0, 4'h0);
        settle();
        checks++;
        if (act_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL rst_resp_grant got=%b want=01", act_ready);
        end
        advance();
        req_valid = 2'b00;
        reset     = 1'b1;
        settle();
        advance();
        reset     = 1'b0;
        req_valid = 2'b11;
        set_req(0, 1'b1, 12'h010, 32'h11111111, 4'hF);
        set_req(1, 1'b1, 12'h020, 32'h22222222, 4'hF);
        settle();
        checks++;
        if (act_rv !== 2'b00) begin
            failures++;
            $display("[TB] FAIL rst_resp_dropped got=%b want=00", act_rv);
        end
        checks++;
        if (act_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL rst_resp_favour got=%b want=01", act_ready);
        end
        advance();
        req_valid = 2'b00;
    endtask

`ifdef SRAM_ARB_PERF_EN
    task automatic test_perf();
        req_valid = 2'b00;
        reset     = 1'b1;
        settle();
        advance();
        reset     = 1'b0;
        req_valid = 2'b11;
        set_req(0, 1'b1, 12'h010, 32'h11111111, 4'hF);
        set_req(1, 1'b1, 12'h020, 32'h22222222, 4'hF);
        for (int i = 0; i < 10; i++) begin
            settle();
            advance();
        end
        req_valid = 2'b00;
        settle();
        checks++;
        if (perf_g0 !== 32'd5 || perf_g1 !== 32'd5 || perf_stall !== 32'd0) begin
            failures++;
            $display("[TB] FAIL perf_counts got g0=%0d g1=%0d stall=%0d want 5/5/0", perf_g0, perf_g1, perf_stall);
        end
        advance();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 39) == 0);
            req_valid  = 2'($urandom);
            resp_ready = 2'($urandom_range(0, 3));
            for (int n = 0; n < 2; n++)
                set_req(n, 1'($urandom), 12'($urandom_range(0, 15)), $urandom, 4'($urandom));
            settle();
            checks++;
            if (act_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL rand_ready[%0d] got=%b want=%b", i, act_ready, exp_ready);
            end
            checks++;
            if (act_rv !== exp_rv) begin
                failures++;
                $display("[TB] FAIL rand_resp_valid[%0d] got=%b want=%b", i, act_rv, exp_rv);
            end
            if (exp_rv[0]) begin
                checks++;
                if (rdata0 !== m_pdata) begin
                    failures++;
                    $display("[TB] FAIL rand_rdata0[%0d] got=%h want=%h", i, rdata0, m_pdata);
                end
            end
            if (exp_rv[1]) begin
                checks++;
                if (rdata1 !== m_pdata) begin
                    failures++;
                    $display("[TB] FAIL rand_rdata1[%0d] got=%h want=%h", i, rdata1, m_pdata);
                end
            end
            checks++;
            if (w_en !== exp_w_en || r_en !== exp_r_en) begin
                failures++;
                $display("[TB] FAIL rand_mem_en[%0d] got w=%b r=%b want w=%b r=%b", i, w_en, r_en, exp_w_en, exp_r_en);
            end
            checks++;
            if (exp_w_en ? (w_addr !== req_addr[g_sel] || w_data !== req_wdata[g_sel] || w_mask !== req_mask[g_sel])
                         : ({w_addr, w_data, w_mask} !== 48'h0)) begin
                failures++;
                $display("[TB] FAIL rand_wbus[%0d] got addr=%h data=%h mask=%b", i, w_addr, w_data, w_mask);
            end
            checks++;
            if (r_addr !== (exp_r_en ? req_addr[g_sel] : 12'h0)) begin
                failures++;
                $display("[TB] FAIL rand_raddr[%0d] got=%h want=%h", i, r_addr, exp_r_en ? req_addr[g_sel] : 12'h0);
            end
            advance();
        end
        reset     = 1'b0;
        req_valid = 2'b00;
    endtask

    initial begin
        reset      = 1'b1;
        preload    = 1'b1;
        req_valid  = 2'b00;
        req_write  = 2'b00;
        resp_ready = 2'b00;
        for (int n = 0; n < 2; n++) set_req(n, 1'b0, 12'h0, 32'h0, 4'h0);
        for (int i = 0; i < 4096; i++) shadow[i] = init_word(i);
        m_fav   = 1'b0;
        m_pend  = 1'b0;
        m_owner = 1'b0;
        m_pdata = 32'h0;
        @(posedge clock);
        #1;
        preload = 1'b0;

        test_reset();
        test_alternating_writes();
        test_masked_write_read();
        test_zero_mask();
        test_back_to_back();
        test_stall();
        test_reset_in_resp();
`ifdef SRAM_ARB_PERF_EN
        test_perf();
`endif
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
